// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter that shares one router injection port
// between NUM_REQ flit sources, with a packet counter and sticky error flag.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int GNT_W = $clog2(NUM_REQ)
) (
  input  logic                               noc_clk,
  input  logic                               noc_rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*`Noc_Data_Width-1:0] req_flit,
  input  logic [NUM_REQ-1:0]                 req_is_header,
  input  logic [NUM_REQ-1:0]                 req_is_tail,
  output logic                               sender_valid,
  input  logic                               sender_ready,
  output logic [`Noc_Data_Width-1:0]         sender_flit,
  output logic                               sender_is_header,
  output logic                               sender_is_tail,
  output logic                               grant_valid,
  output logic [GNT_W-1:0]                   grant_idx,
  output logic [15:0]                        pkt_count,
  output logic                               proto_err
);

  localparam int DW = `Noc_Data_Width;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state;
  logic [GNT_W-1:0] rr_ptr;
  logic [GNT_W-1:0] rr_next;
  logic             first_done;
  logic [DW-1:0]    flit_arr [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [GNT_W-1:0] pick_idx;
  logic             pick_found;
  logic             lock;
  logic             hs;
  logic             tail_hs;
  logic             idle_err;
  logic             mid_err;

  assign lock = (state == LOCK);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign flit_arr[gi]  = req_flit[gi*DW +: DW];
      assign req_ready[gi] = lock && (grant_idx == GNT_W'(gi)) && sender_ready;
    end
  endgenerate

  // Zero-latency pass-through of the locked requester; forced to 0 outside LOCK.
  assign sender_valid     = lock & req_valid[grant_idx];
  assign sender_flit      = lock ? flit_arr[grant_idx] : '0;
  assign sender_is_header = lock & req_is_header[grant_idx];
  assign sender_is_tail   = lock & req_is_tail[grant_idx];

  assign hs       = sender_valid & sender_ready;
  assign tail_hs  = hs & req_is_tail[grant_idx];
  assign eligible = req_valid & req_is_header;
  assign idle_err = !lock && |(req_valid & ~req_is_header);
  assign mid_err  = lock && first_done && req_valid[grant_idx] && req_is_header[grant_idx];
  assign rr_next  = (grant_idx == GNT_W'(NUM_REQ - 1)) ? '0 : grant_idx + GNT_W'(1);

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    int               idx;
    logic [GNT_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = GNT_W'(idx);
      if (eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      pkt_count   <= '0;
      proto_err   <= 1'b0;
      first_done  <= 1'b0;
    end else begin
      if (idle_err || mid_err) begin
        proto_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            first_done  <= 1'b0;
            state       <= LOCK;
          end
        end
        LOCK: begin
          if (hs) begin
            first_done <= 1'b1;
          end
          if (tail_hs) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            rr_ptr      <= rr_next;
            pkt_count   <= pkt_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: per-source flit queues feed the DUT,
// an expected-flit scoreboard is checked at every negative clock edge.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module tb_noc_inject_arbiter;

  localparam int NR = 4;
  localparam int DW = `Noc_Data_Width;

  typedef struct packed {
    logic [DW-1:0] flit;
    logic          hdr;
    logic          tail;
  } src_t;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] flit;
    logic          hdr;
    logic          tail;
  } exp_t;

  logic             clk = 1'b0;
  logic             noc_rst_n = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_flit = '0;
  logic [NR-1:0]    req_is_header = '0;
  logic [NR-1:0]    req_is_tail = '0;
  logic             sender_valid;
  logic             sender_ready = 1'b0;
  logic [DW-1:0]    sender_flit;
  logic             sender_is_header;
  logic             sender_is_tail;
  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [15:0]      pkt_count;
  logic             proto_err;

  noc_inject_arbiter #(.NUM_REQ(NR)) dut (
    .noc_clk          (clk),
    .noc_rst_n        (noc_rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_flit         (req_flit),
    .req_is_header    (req_is_header),
    .req_is_tail      (req_is_tail),
    .sender_valid     (sender_valid),
    .sender_ready     (sender_ready),
    .sender_flit      (sender_flit),
    .sender_is_header (sender_is_header),
    .sender_is_tail   (sender_is_tail),
    .grant_valid      (grant_valid),
    .grant_idx        (grant_idx),
    .pkt_count        (pkt_count),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  src_t src_q [NR][$];
  exp_t exp_q [$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_n = 0;
  int   hs_first = 0;
  int   hs_last = 0;
  bit   mark_first = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic present();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_flit[i*DW +: DW] = src_q[i][0].flit;
        req_is_header[i]     = src_q[i][0].hdr;
        req_is_tail[i]       = src_q[i][0].tail;
      end else begin
        req_valid[i]         = 1'b0;
        req_flit[i*DW +: DW] = '0;
        req_is_header[i]     = 1'b0;
        req_is_tail[i]       = 1'b0;
      end
    end
  endtask

  task automatic push_flit(input int s, input logic [DW-1:0] f, input logic h, input logic t,
                           input bit expect_out);
    src_t sv;
    exp_t ev;
    sv.flit = f;
    sv.hdr  = h;
    sv.tail = t;
    src_q[s].push_back(sv);
    if (expect_out) begin
      ev.src  = 2'(s);
      ev.flit = f;
      ev.hdr  = h;
      ev.tail = t;
      exp_q.push_back(ev);
    end
  endtask

  task automatic send_pkt(input int s, input logic [DW-1:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      push_flit(s, base + DW'(j), (j == 0), (j == n - 1), 1'b1);
    end
    present();
  endtask

  // Output-side scoreboard check, run while inputs are stable mid-cycle.
  task automatic observe();
    exp_t          e;
    logic [NR-1:0] rdy_exp;
    if (!grant_valid) begin
      check("idle_sender_valid", 64'(sender_valid), 64'(0));
      check("idle_req_ready", 64'(req_ready), 64'(0));
    end else if (exp_q.size() == 0) begin
      check("unexpected_grant", 64'(grant_valid), 64'(0));
    end else begin
      e = exp_q[0];
      rdy_exp = '0;
      rdy_exp[e.src] = sender_ready;
      check("grant_idx", 64'(grant_idx), 64'(e.src));
      check("req_ready", 64'(req_ready), 64'(rdy_exp));
      if (sender_valid && sender_ready) begin
        void'(exp_q.pop_front());
        check("sender_flit", 64'(sender_flit), 64'(e.flit));
        check("sender_is_header", 64'(sender_is_header), 64'(e.hdr));
        check("sender_is_tail", 64'(sender_is_tail), 64'(e.tail));
        if (mark_first) begin
          hs_first   = cyc;
          mark_first = 1'b0;
        end
        hs_last = cyc;
        hs_n++;
      end
    end
  endtask

  task automatic step();
    logic [NR-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    observe();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
      end
    end
    present();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sender_valid"}, 64'(sender_valid), 64'(0));
    check({tag, "_sender_flit"}, 64'(sender_flit), 64'(0));
    check({tag, "_sender_hdr_tail"}, 64'({sender_is_header, sender_is_tail}), 64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_grant"}, 64'({grant_valid, grant_idx}), 64'(0));
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'(0));
    check({tag, "_proto_err"}, 64'(proto_err), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    noc_rst_n = 1'b0;
    #1;
    check_reset(tag);
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
    end
    present();
    step();
    step();
    noc_rst_n = 1'b1;
    check({tag, "_rr_ptr"}, 64'(dut.rr_ptr), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc0;
    int hs0;

    #2;
    do_reset("rst_init");

    // Single 3-flit packet from requester 2.
    sender_ready = 1'b1;
    cyc0 = cyc;
    mark_first = 1'b1;
    send_pkt(2, 32'hA1, 3);
    drain("single", 20);
    check("single_first_hs_cycle", 64'(hs_first), 64'(cyc0 + 1));
    check("single_last_hs_cycle", 64'(hs_last), 64'(cyc0 + 3));
    check("single_pkt_count", 64'(pkt_count), 64'(1));
    check("single_rr_ptr", 64'(dut.rr_ptr), 64'(3));
    check("single_grant_valid", 64'(grant_valid), 64'(0));

    // Round-robin fairness: every source offers two back-to-back 2-flit packets.
    do_reset("rst_rr");
    sender_ready = 1'b1;
    cyc0 = cyc;
    mark_first = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NR; s++) begin
        send_pkt(s, 32'h100 * (s + 1) + 32'h10 * r, 2);
      end
    end
    drain("rr", 60);
    check("rr_first_hs_cycle", 64'(hs_first), 64'(cyc0 + 1));
    check("rr_span", 64'(hs_last - hs_first), 64'(22));
    check("rr_pkt_count", 64'(pkt_count), 64'(8));
    check("rr_proto_err", 64'(proto_err), 64'(0));

    // Backpressure on a 4-flit packet from requester 1: ready pattern 1,0,0,1,...
    hs0 = hs_n;
    send_pkt(1, 32'hB1, 4);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      sender_ready = (k % 3 == 0);
      step();
    end
    sender_ready = 1'b1;
    check("bp_drain_left", 64'(exp_q.size()), 64'(0));
    check("bp_handshakes", 64'(hs_n - hs0), 64'(4));
    check("bp_pkt_count", 64'(pkt_count), 64'(9));

    // Single-flit packets from 3 and 0; rr_ptr is 2 so 3 goes first.
    cyc0 = cyc;
    mark_first = 1'b1;
    send_pkt(3, 32'hD3, 1);
    send_pkt(0, 32'hD0, 1);
    drain("sflit", 20);
    check("sflit_first_hs_cycle", 64'(hs_first), 64'(cyc0 + 1));
    check("sflit_last_hs_cycle", 64'(hs_last), 64'(cyc0 + 3));
    check("sflit_pkt_count", 64'(pkt_count), 64'(11));

    // Header flit in the middle of a packet: forwarded unchanged, error latched.
    do_reset("rst_mid");
    push_flit(2, 32'hC1, 1'b1, 1'b0, 1'b1);
    push_flit(2, 32'hC2, 1'b1, 1'b0, 1'b1);
    push_flit(2, 32'hC3, 1'b0, 1'b1, 1'b1);
    present();
    drain("midhdr", 20);
    check("midhdr_proto_err", 64'(proto_err), 64'(1));
    check("midhdr_pkt_count", 64'(pkt_count), 64'(1));

    // Non-header flit offered in IDLE: error latched, requester stalled.
    do_reset("rst_idle");
    push_flit(1, 32'hE1, 1'b0, 1'b0, 1'b0);
    present();
    for (int k = 0; k < 3; k++) begin
      step();
    end
    check("idleerr_proto_err", 64'(proto_err), 64'(1));
    check("idleerr_grant_valid", 64'(grant_valid), 64'(0));
    check("idleerr_req_ready", 64'(req_ready), 64'(0));
    send_pkt(2, 32'hE2, 2);
    drain("idleerr_other", 20);
    check("idleerr_stalled_left", 64'(src_q[1].size()), 64'(1));
    check("idleerr_pkt_count", 64'(pkt_count), 64'(1));
    src_q[1].delete();
    present();

    // Reset after flit 2 of a 4-flit packet from requester 3.
    hs0 = hs_n;
    send_pkt(3, 32'hF1, 4);
    step();
    step();
    step();
    check("midrst_handshakes", 64'(hs_n - hs0), 64'(2));
    check("midrst_locked", 64'(grant_valid), 64'(1));
    do_reset("midrst");
    step();
    check("midrst_grant_after", 64'(grant_valid), 64'(0));
    check("midrst_pkt_after", 64'(pkt_count), 64'(0));
    send_pkt(0, 32'h70, 2);
    drain("postrst", 20);
    check("postrst_pkt_count", 64'(pkt_count), 64'(1));
    check("postrst_rr_ptr", 64'(dut.rr_ptr), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
